// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between I-side fetch and D-side load/store, one transaction
// in flight. D-side has priority, capped at MAX_D_STREAK back-to-back grants while I-side waits.
module mem_port_arbiter #(
    parameter int unsigned CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_req_i,
    input  logic [ADDRESS_BITS-1:0] i_addr_i,
    output logic                    i_ready_o,
    output logic                    i_valid_o,
    output logic [DATA_WIDTH-1:0]   i_data_o,
    input  logic                    d_read_i,
    input  logic                    d_write_i,
    input  logic [ADDRESS_BITS-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_ready_o,
    output logic                    d_valid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDRESS_BITS-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    protocol_err_o,
    input  logic                    report_i,
    output logic                    report_o,
    output logic [31:0]             report_core_o,
    output logic [31:0]             i_grants_o,
    output logic [31:0]             d_grants_o,
    output logic [31:0]             conflict_cycles_o
);

    localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q;
    logic                owner_d_q;
    logic [StreakW-1:0]  d_streak_q;
    logic                report_q;
    logic [31:0]         i_grants_q;
    logic [31:0]         d_grants_q;
    logic [31:0]         conflict_q;

    logic                d_any;
    logic                i_starved;
    logic                grant_d;
    logic                grant_i;
    logic                conflict;
    logic                acked;
    logic [StreakW-1:0]  streak_inc;

    always_comb begin
        d_any      = d_read_i | d_write_i;
        i_starved  = i_req_i && (d_streak_q == StreakMax);
        grant_d    = d_any && !i_starved;
        grant_i    = !grant_d && i_req_i;
        conflict   = i_req_i && d_any;
        streak_inc = (d_streak_q == StreakMax) ? d_streak_q : d_streak_q + 1'b1;
        acked      = (state_q == StReq) && mem_ack_i;
    end

    assign i_ready_o         = acked && !owner_d_q;
    assign d_ready_o         = acked && owner_d_q;
    assign report_o          = report_i && !report_q;
    assign report_core_o     = CORE;
    assign i_grants_o        = i_grants_q;
    assign d_grants_o        = d_grants_q;
    assign conflict_cycles_o = conflict_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            owner_d_q      <= 1'b0;
            d_streak_q     <= '0;
            report_q       <= 1'b0;
            i_grants_q     <= '0;
            d_grants_q     <= '0;
            conflict_q     <= '0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            i_valid_o      <= 1'b0;
            d_valid_o      <= 1'b0;
            i_data_o       <= '0;
            d_rdata_o      <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            i_valid_o <= 1'b0;
            d_valid_o <= 1'b0;
            report_q  <= report_i;
            if (conflict) begin
                conflict_q <= conflict_q + 32'd1;
            end
            case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        // Simultaneous read+write is resolved as a write and flagged.
                        owner_d_q   <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_write_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        d_streak_q  <= i_req_i ? streak_inc : '0;
                        d_grants_q  <= d_grants_q + 32'd1;
                        if (d_read_i && d_write_i) begin
                            protocol_err_o <= 1'b1;
                        end
                        state_q <= StReq;
                    end else if (grant_i) begin
                        owner_d_q   <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= i_addr_i;
                        mem_wdata_o <= '0;
                        d_streak_q  <= '0;
                        i_grants_q  <= i_grants_q + 32'd1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= mem_we_o ? StIdle : StResp;
                    end
                end
                StResp: begin
                    if (mem_rvalid_i) begin
                        if (owner_d_q) begin
                            d_rdata_o <= mem_rdata_i;
                            d_valid_o <= 1'b1;
                        end else begin
                            i_data_o  <= mem_rdata_i;
                            i_valid_o <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle, plus
// directed scenarios with hand-derived literal expectations.
module tb_mem_port_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned AB   = 20;
    localparam int unsigned MAXS = 4;
    localparam int unsigned CORE = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req = 1'b0;
    logic [AB-1:0] i_addr = '0;
    logic          i_ready, i_valid;
    logic [DW-1:0] i_data;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AB-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready, d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_req, mem_we;
    logic [AB-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          perr;
    logic          report = 1'b0, report_pulse;
    logic [31:0]   rep_core, i_grants, d_grants, conf_cycles;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    mem_port_arbiter #(
        .CORE(CORE), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .MAX_D_STREAK(MAXS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_ready_o(i_ready), .i_valid_o(i_valid),
        .i_data_o(i_data),
        .d_read_i(d_read), .d_write_i(d_write), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ready_o(d_ready), .d_valid_o(d_valid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .protocol_err_o(perr), .report_i(report), .report_o(report_pulse),
        .report_core_o(rep_core), .i_grants_o(i_grants), .d_grants_o(d_grants),
        .conflict_cycles_o(conf_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] rd_val(input logic [AB-1:0] a);
        if (a == 20'h100) return 32'hDEADBEEF;
        return {12'h0, a} ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: ack after ack_delay waiting cycles, read data rv_delay cycles after ack+1.
    int ack_delay = 0, rv_delay = 0, ack_cnt = 0, rv_cnt = 0;
    bit pend_read = 1'b0;
    logic [AB-1:0] pend_addr = '0;

    always @(posedge clk) begin
        #2;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        if (mem_req) begin
            if (ack_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                ack_cnt = 0;
                if (!mem_we) begin
                    pend_read = 1'b1;
                    pend_addr = mem_addr;
                    rv_cnt = 0;
                end
            end else begin
                ack_cnt++;
            end
        end else if (pend_read) begin
            if (rv_cnt >= rv_delay) begin
                mem_rvalid = 1'b1;
                mem_rdata = rd_val(pend_addr);
                pend_read = 1'b0;
            end else begin
                rv_cnt++;
            end
        end
    end

    // Reference model: phase 0 = free, 1 = request issued awaiting ack, 2 = awaiting read data.
    int            m_phase, m_streak;
    bit            m_is_d, m_req, m_we, m_iv, m_dv, m_perr, m_rep_q;
    logic [AB-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_idata, m_ddata;
    logic [31:0]   m_ig, m_dg, m_cc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_streak = 0; m_is_d = 0; m_req = 0; m_we = 0; m_iv = 0; m_dv = 0;
            m_perr = 0; m_rep_q = 0; m_addr = '0; m_wdata = '0; m_idata = '0; m_ddata = '0;
            m_ig = 0; m_dg = 0; m_cc = 0;
        end else begin
            m_iv = 0;
            m_dv = 0;
            if (i_req && (d_read || d_write)) m_cc++;
            m_rep_q = report;
            if (m_phase == 0) begin
                if ((d_read || d_write) && !(i_req && m_streak == MAXS)) begin
                    m_is_d = 1; m_req = 1; m_we = d_write; m_addr = d_addr; m_wdata = d_wdata;
                    if (d_read && d_write) m_perr = 1;
                    m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                    m_dg++;
                    m_phase = 1;
                end else if (i_req) begin
                    m_is_d = 0; m_req = 1; m_we = 0; m_addr = i_addr; m_wdata = '0;
                    m_streak = 0;
                    m_ig++;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (mem_ack) begin
                    m_req = 0;
                    m_phase = m_we ? 0 : 2;
                end
            end else if (mem_rvalid) begin
                if (m_is_d) begin m_ddata = mem_rdata; m_dv = 1; end
                else begin m_idata = mem_rdata; m_iv = 1; end
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_mem_req", mem_req, m_req);
            chk("m_mem_we", mem_we, m_we);
            chk("m_mem_addr", mem_addr, m_addr);
            chk("m_mem_wdata", mem_wdata, m_wdata);
            chk("m_i_ready", i_ready, m_phase == 1 && !m_is_d && mem_ack);
            chk("m_d_ready", d_ready, m_phase == 1 && m_is_d && mem_ack);
            chk("m_i_valid", i_valid, m_iv);
            chk("m_d_valid", d_valid, m_dv);
            chk("m_i_data", i_data, m_idata);
            chk("m_d_rdata", d_rdata, m_ddata);
            chk("m_perr", perr, m_perr);
            chk("m_report", report_pulse, report && !m_rep_q);
            chk("m_i_grants", i_grants, m_ig);
            chk("m_d_grants", d_grants, m_dg);
            chk("m_conflicts", conf_cycles, m_cc);
        end
        if (report_pulse)
            $display("core %0d report: i_grants=%0d d_grants=%0d conflict_cycles=%0d",
                     rep_core, i_grants, d_grants, conf_cycles);
    end

    task automatic do_txn(input bit is_d, input logic [AB-1:0] a);
        bit got;
        step();
        if (is_d) begin d_read = 1'b1; d_addr = a; end
        else begin i_req = 1'b1; i_addr = a; end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) got = 1'b1;
        end
        chk("txn_ready_seen", got, 1'b1);
        step();
        d_read = 1'b0;
        i_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (is_d ? d_valid : i_valid) got = 1'b1;
        end
        chk("txn_valid_seen", got, 1'b1);
    endtask

    bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit got_d [10];

    initial begin
        int ng, pulses;
        bit prev;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_valids", {i_valid, d_valid, i_ready, d_ready}, 4'b0);
        chk("rst_counters", {i_grants, d_grants, conf_cycles}, 96'b0);

        // Lone I read at 0x100.
        step(); i_req = 1'b1; i_addr = 20'h100;
        @(negedge clk); chk("i_c0_mem_req", mem_req, 1'b0);
        step();
        @(negedge clk);
        chk("i_c1_mem_req", mem_req, 1'b1);
        chk("i_c1_addr", mem_addr, 20'h100);
        chk("i_c1_ready", i_ready, 1'b1);
        step(); i_req = 1'b0;
        @(negedge clk); chk("i_c2_valid", i_valid, 1'b0);
        step();
        @(negedge clk);
        chk("i_c3_valid", i_valid, 1'b1);
        chk("i_c3_data", i_data, 32'hDEADBEEF);
        chk("i_c3_d_side", {d_valid, d_rdata}, 33'b0);

        // D store with delayed ack.
        ack_delay = 3;
        step(); d_write = 1'b1; d_addr = 20'h40; d_wdata = 32'h5;
        for (int c = 1; c <= 3; c++) begin
            step();
            @(negedge clk);
            chk("st_hold", {mem_req, mem_we, mem_addr, mem_wdata, d_ready},
                {1'b1, 1'b1, 20'h40, 32'h5, 1'b0});
        end
        step();
        @(negedge clk); chk("st_ready", d_ready, 1'b1);
        step(); d_write = 1'b0; ack_delay = 0;
        @(negedge clk); chk("st_c5", {mem_req, d_valid}, 2'b0);
        step();
        @(negedge clk); chk("st_c6_dvalid", d_valid, 1'b0);

        // Read and write together: issued as a write, sticky error.
        step(); d_read = 1'b1; d_write = 1'b1; d_addr = 20'h44; d_wdata = 32'h77;
        step();
        @(negedge clk);
        chk("pe_we", mem_we, 1'b1);
        chk("pe_err", perr, 1'b1);
        step(); d_read = 1'b0; d_write = 1'b0;
        repeat (3) step();

        // Starvation limit with both sides requesting continuously.
        step(); i_req = 1'b1; i_addr = 20'h200; d_read = 1'b1; d_addr = 20'h300;
        ng = 0;
        prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_req && !prev && ng < 10) begin
                got_d[ng] = (mem_addr == 20'h300);
                ng++;
            end
            prev = mem_req;
        end
        step(); i_req = 1'b0; d_read = 1'b0;
        chk("streak_grants", ng, 10);
        for (int k = 0; k < 10; k++) chk($sformatf("streak_order_%0d", k), got_d[k], exp_d[k]);
        repeat (6) step();
        @(negedge clk); chk("pe_sticky", perr, 1'b1);

        // Reset while waiting for read data; the late rvalid must be ignored.
        rv_delay = 3;
        step(); i_req = 1'b1; i_addr = 20'h120;
        step();
        @(negedge clk); chk("rr_ready", i_ready, 1'b1);
        step(); rst_n = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("rr_mem_req", mem_req, 1'b0);
        chk("rr_counters", {i_grants, d_grants, conf_cycles, 31'b0, perr}, 128'b0);
        step(); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rr_quiet", {mem_req, i_valid, d_valid}, 3'b0);
            step();
        end
        rv_delay = 1;

        // 10 I reads and 5 D reads, then a report.
        for (int k = 0; k < 10; k++) do_txn(1'b0, AB'(20'h500 + k));
        for (int k = 0; k < 5; k++) do_txn(1'b1, AB'(20'h600 + k));
        step(); report = 1'b1;
        @(negedge clk);
        chk("rep_pulse", report_pulse, 1'b1);
        chk("rep_i_grants", i_grants, 32'd10);
        chk("rep_d_grants", d_grants, 32'd5);
        chk("rep_conflicts", conf_cycles, 32'd0);
        chk("rep_core", rep_core, 32'(CORE));
        pulses = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            if (report_pulse) pulses++;
        end
        chk("rep_once", pulses, 1);
        step(); report = 1'b0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
